ifu_inst_buffer: RTL and testbench

//  Instruction buffer at the receiving end of the predecode->instbuffer channel.

---
 rtl/ifu_inst_buffer.sv | 109 ++++++++++
 tb/tb_ifu_inst_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_buffer.sv
// Instruction buffer: compacts sparse predecode bundles into an in-order
// circular FIFO and offers the oldest OUT_WIDTH entries to decode.
module ifu_inst_buffer #(
    parameter int BANK      = 4,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 16,
    parameter int FSQ_W     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [BANK-1:0]            in_en,
    input  logic [$clog2(BANK)-1:0]    in_num,
    input  logic [BANK*32-1:0]         in_inst,
    input  logic [FSQ_W-1:0]           in_fsqIdx,
    output logic                       in_ready,
    output logic [OUT_WIDTH-1:0]       out_valid,
    output logic [OUT_WIDTH*32-1:0]    out_inst,
    output logic [OUT_WIDTH*FSQ_W-1:0] out_fsqIdx,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = $clog2(BANK);
    localparam int BW = NW + 1;
    localparam int OW = $clog2(OUT_WIDTH) + 1;

    logic [31:0]      inst_q [DEPTH];
    logic [FSQ_W-1:0] fsq_q  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [BW-1:0] enq_n;
    logic [OW-1:0] deq_n;
    logic [AW-1:0] slot_off [BANK];
    logic          enq_fire;
    logic          deq_fire;

    assign count    = tail - head;
    assign in_ready = (PW'(DEPTH) - count) >= PW'(BANK);
    assign enq_fire = (|in_en) && in_ready && !flush;
    assign deq_fire = out_ready && !flush;

    // Each valid bank lands at tail plus the number of valid banks below it.
    always_comb begin
        enq_n = '0;
        for (int b = 0; b < BANK; b++) begin
            slot_off[b] = AW'(enq_n);
            enq_n       = enq_n + BW'(in_en[b]);
        end
    end

    always_comb begin
        deq_n      = '0;
        out_valid  = '0;
        out_inst   = '0;
        out_fsqIdx = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_valid[i] = count > PW'(i);
            if (out_valid[i]) begin
                deq_n = deq_n + OW'(1);
                out_inst[i*32 +: 32] =
                    inst_q[head[AW-1:0] + AW'(i)];
                out_fsqIdx[i*FSQ_W +: FSQ_W] =
                    fsq_q[head[AW-1:0] + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) tail <= tail + PW'(enq_n);
            if (deq_fire) head <= head + PW'(deq_n);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int b = 0; b < BANK; b++) begin
                if (in_en[b]) begin
                    inst_q[tail[AW-1:0] + slot_off[b]] <=
                        in_inst[b*32 +: 32];
                    fsq_q[tail[AW-1:0] + slot_off[b]] <= in_fsqIdx;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_in_num: assert property (
        @(posedge clk) disable iff (!rst_n)
        (|in_en) |-> (in_num == NW'(enq_n - BW'(1)))
    );
    a_count: assert property (
        @(posedge clk) disable iff (!rst_n)
        count <= PW'(DEPTH)
    );
`endif

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Directed test of ifu_inst_buffer: compaction, back-pressure,
// wrap-around, simultaneous enqueue/dequeue and flush.
module tb_ifu_inst_buffer;

    localparam int FSQ_W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   in_en;
    logic [1:0]   in_num;
    logic [127:0] in_inst;
    logic [5:0]   in_fsqIdx;
    logic         in_ready;
    logic [3:0]   out_valid;
    logic [127:0] out_inst;
    logic [23:0]  out_fsqIdx;
    logic         out_ready;
    logic [4:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] IA = 32'hAAAA_0001;
    localparam logic [31:0] IB = 32'hBBBB_0002;
    localparam logic [31:0] IC = 32'hCCCC_0003;
    localparam logic [31:0] ID = 32'hDDDD_0004;

    always #5 clk = ~clk;

    ifu_inst_buffer #(
        .BANK(4), .OUT_WIDTH(4), .DEPTH(16), .FSQ_W(FSQ_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_en(in_en), .in_num(in_num), .in_inst(in_inst),
        .in_fsqIdx(in_fsqIdx), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst),
        .out_fsqIdx(out_fsqIdx), .out_ready(out_ready),
        .count(count)
    );

    function automatic logic [31:0] w(input int n);
        return 32'hC0DE_0000 | 32'(n);
    endfunction

    function automatic logic [127:0] bw(input int n);
        return {w(n+3), w(n+2), w(n+1), w(n)};
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [1:0] num,
                         input logic [127:0] inst, input logic [5:0] fsq,
                         input logic ordy);
        in_en     = en;
        in_num    = num;
        in_inst   = inst;
        in_fsqIdx = fsq;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(4'b0000, 2'd0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_ready", 128'(in_ready), 128'd1);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_inst", out_inst, 128'd0);
        chk("rst_fsq", 128'(out_fsqIdx), 128'd0);
        rst_n = 1'b1;
        cyc();

        // Full bundle
        drive(4'b1111, 2'd3, {ID, IC, IB, IA}, 6'd3, 1'b0);
        cyc();
        drive(4'b0000, 2'd0, '0, '0, 1'b0);
        chk("t1_valid", 128'(out_valid), 128'hF);
        chk("t1_inst", out_inst, {ID, IC, IB, IA});
        chk("t1_fsq", 128'(out_fsqIdx), 128'({6'd3, 6'd3, 6'd3, 6'd3}));
        chk("t1_count", 128'(count), 128'd4);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t1_drain", 128'(count), 128'd0);

        // Sparse bundle compaction
        drive(4'b1010, 2'd1, {ID, IC, IB, IA}, 6'd5, 1'b0);
        cyc();
        drive(4'b0000, 2'd0, '0, '0, 1'b0);
        chk("t2_valid", 128'(out_valid), 128'h3);
        chk("t2_inst", out_inst, {32'd0, 32'd0, ID, IB});
        chk("t2_fsq", 128'(out_fsqIdx), 128'({6'd0, 6'd0, 6'd5, 6'd5}));
        chk("t2_count", 128'(count), 128'd2);

        // Fill to 13, then back-pressure
        drive(4'b1111, 2'd3, bw(1), 6'd1, 1'b0);
        cyc();
        drive(4'b1111, 2'd3, bw(5), 6'd2, 1'b0);
        cyc();
        chk("t3_ready10", 128'(in_ready), 128'd1);
        drive(4'b0111, 2'd2, bw(9), 6'd3, 1'b0);
        cyc();
        chk("t3_count13", 128'(count), 128'd13);
        chk("t3_notready", 128'(in_ready), 128'd0);
        drive(4'b0001, 2'd0, bw(99), 6'd4, 1'b0);
        cyc();
        chk("t3_dropped", 128'(count), 128'd13);
        chk("t3_head", out_inst, {w(2), w(1), ID, IB});
        drive(4'b0000, 2'd0, '0, '0, 1'b1);
        cyc();
        chk("t3_deq_count", 128'(count), 128'd9);
        chk("t3_deq_inst", out_inst, bw(3));
        chk("t3_deq_ready", 128'(in_ready), 128'd1);

        // Flush beats a same-cycle full bundle
        flush = 1'b1;
        drive(4'b1111, 2'd3, bw(40), 6'd9, 1'b1);
        cyc();
        flush = 1'b0;
        drive(4'b0000, 2'd0, '0, '0, 1'b1);
        chk("t6_count", 128'(count), 128'd0);
        chk("t6_valid", 128'(out_valid), 128'd0);
        chk("t6_ready", 128'(in_ready), 128'd1);
        chk("t6_inst", out_inst, 128'd0);
        cyc();
        chk("empty_deq", 128'(count), 128'd0);

        // Enqueue and dequeue in the same cycle
        drive(4'b1111, 2'd3, bw(100), 6'd10, 1'b0);
        cyc();
        drive(4'b0011, 2'd1, bw(104), 6'd11, 1'b0);
        cyc();
        chk("t5_count6", 128'(count), 128'd6);
        drive(4'b0111, 2'd2, bw(106), 6'd12, 1'b1);
        cyc();
        drive(4'b0000, 2'd0, '0, '0, 1'b0);
        chk("t5_count", 128'(count), 128'd5);
        chk("t5_inst", out_inst, bw(104));
        chk("t5_fsq", 128'(out_fsqIdx),
            128'({6'd12, 6'd12, 6'd11, 6'd11}));

        // Advance head to 14 with an empty buffer
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("t4_empty9", 128'(count), 128'd0);
        drive(4'b1111, 2'd3, bw(200), 6'd1, 1'b0);
        cyc();
        drive(4'b0001, 2'd0, bw(204), 6'd1, 1'b0);
        cyc();
        drive(4'b0000, 2'd0, '0, '0, 1'b1);
        cyc();
        cyc();
        chk("t4_empty14", 128'(count), 128'd0);
        chk("t4_valid0", 128'(out_valid), 128'd0);

        // Bundle spanning entries 14,15,0,1
        drive(4'b1111, 2'd3, bw(300), 6'd7, 1'b0);
        cyc();
        chk("t4_count", 128'(count), 128'd4);
        chk("t4_inst", out_inst, bw(300));
        chk("t4_fsq", 128'(out_fsqIdx), 128'({6'd7, 6'd7, 6'd7, 6'd7}));
        drive(4'b1111, 2'd3, bw(400), 6'd9, 1'b1);
        cyc();
        chk("t4_swap_count", 128'(count), 128'd4);
        chk("t4_swap_inst", out_inst, bw(400));
        drive(4'b0110, 2'd1, bw(500), 6'd2, 1'b0);
        cyc();
        chk("t4_sparse_count", 128'(count), 128'd6);
        chk("t4_sparse_hold", out_inst, bw(400));
        drive(4'b0000, 2'd0, '0, '0, 1'b1);
        cyc();
        out_ready = 1'b0;
        chk("t4_tail_valid", 128'(out_valid), 128'h3);
        chk("t4_tail_inst", out_inst, {32'd0, 32'd0, w(502), w(501)});

        // Asynchronous reset mid-traffic
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_valid", 128'(out_valid), 128'd0);
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
